display_formatter: RTL
======================

DISPLAY_FORMATTER -- requirements
Module: display_formatter

Interface
REQ-001 The module SHALL expose the following ports, clock and reset first.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous reset, active-high.
- start  input  1  request to convert value; sampled only in IDLE.
- value  input  14  signed two's-complement result, -8192..8191.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digit codes are valid.
- digit0..digit4  output  4 each  display codes; digit0 is least significant; codes 0-9 decimal, 10 blank, 11 minus; feeds one segment7 decoder per position.

Function
REQ-002 The FSM SHALL have states IDLE, CONVERT and FORMAT.
- IDLE -> CONVERT on start=1.
- CONVERT -> FORMAT after 14 shift steps.
- FORMAT -> IDLE unconditionally.
REQ-003 On the edge that samples start in IDLE, the module SHALL:
- capture sign = value[13] and magnitude = |value| as 14-bit unsigned;
- clear the BCD accumulator (16 bits, 4 nibbles) and the step counter;
- set busy=1.
REQ-004 In CONVERT, each edge SHALL perform one double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd, magnitude} left by one; 14 steps exactly.
REQ-005 On the FORMAT edge, the module SHALL:
- register digit0..digit4;
- set done=1 for exactly one cycle;
- clear busy.
This edge is the 15th rising edge after the start-sampling edge.
REQ-006 Leading-zero blanking: every position above the most significant nonzero BCD digit SHALL be 10; digit0 SHALL always show a numeral, including 0.
REQ-007 When sign=1, the position immediately above the most significant nonzero digit SHALL be 11 (minus).
REQ-008 digit4 SHALL only ever be 10 or 11, since the magnitude is at most 8192.
REQ-009 -8192 SHALL convert to magnitude 8192, since the 14-bit negation of 0x2000 is reinterpreted as unsigned.
REQ-010 start SHALL be ignored while busy=1; value changes during CONVERT SHALL NOT affect the result.
REQ-011 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted, giving back-to-back conversions every 16 cycles.
REQ-012 digit outputs SHALL hold their last formatted values between conversions and change only on the FORMAT edge.

Reset
REQ-013 reset=1 SHALL take priority over all other inputs on any edge, including mid-CONVERT, and SHALL force:
- state=IDLE, busy=0, done=0;
- digit0=0, digit1..digit4=10 (display shows "0");
- accumulator, magnitude, sign and counter cleared.
REQ-014 A conversion interrupted by reset SHALL NOT produce done and SHALL NOT update the digits.

Structure
REQ-015 A shared package calc_pkg SHALL hold:
- DIG_BLANK=10 and DIG_MINUS=11;
- VAL_W=14 and NDIG=5;
- the FSM state type.
The existing segment7 decoder SHALL use the same constants.
REQ-016 Per-nibble add-3 correction SHALL be a combinational sub-module bcd_adj3 (4-bit in, 4-bit out), instantiated 4 times.
REQ-017 Implementation SHALL be one registered FSM plus a combinational formatting function; no latches, and every case branch SHALL have a default.

Verification
REQ-018 reset, then idle -> digits {4..0} = 10,10,10,10,0; busy=0; done=0.
REQ-019 value=1234, start for 1 cycle -> done at 15th edge; digits = 10,1,2,3,4; busy high for exactly 15 cycles.
REQ-020 value=-5 -> digits = 10,10,10,11,5; value=0 -> 10,10,10,10,0.
REQ-021 value=-8192 -> 11,8,1,9,2; value=8191 -> 10,8,1,9,1.
REQ-022 value=-307 then value changed to 42 at edge 5 with start held high -> result is 10,11,3,0,7; second start ignored; start asserted on the done cycle with value 42 -> second done 16 cycles later, giving 10,10,10,4,2.
REQ-023 reset pulsed at edge 7 of a conversion of 999 -> no done pulse; digits return to the reset pattern; a subsequent start converts normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants, FSM state type and digit formatting helper for the
// calculator display path (also used by the segment7 decoder).
package calc_pkg;

  localparam int VAL_W = 14;
  localparam int NDIG  = 5;
  localparam int BCD_W = 16;

  localparam logic [3:0] DIG_BLANK = 4'd10;
  localparam logic [3:0] DIG_MINUS = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FORMAT
  } state_t;

  // Turns four BCD nibbles plus a sign into five display codes: positions
  // above the most significant nonzero digit are blanked, digit0 always
  // shows a numeral, and a minus sits just above the leading digit.
  function automatic logic [NDIG*4-1:0] format_digits(input logic [BCD_W-1:0] bcd,
                                                       input logic sign);
    logic [NDIG*4-1:0] res;
    int msd;
    msd = 0;
    for (int i = 1; i < 4; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) msd = i;
    end
    res = {DIG_BLANK, bcd};
    for (int i = 1; i < 4; i++) begin
      if (i > msd) res[i*4 +: 4] = DIG_BLANK;
    end
    if (sign) res[(msd+1)*4 +: 4] = DIG_MINUS;
    return res;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5
// or more so the following left shift carries correctly into the next digit.
module bcd_adj3 (
  input  logic [3:0] nibble_in,
  output logic [3:0] nibble_out
);

  // Conditional add-3, purely combinational
  always_comb begin
    nibble_out = nibble_in;
    if (nibble_in >= 4'd5) nibble_out = nibble_in + 4'd3;
  end

endmodule

// File: rtl/display_formatter.sv
// Converts a signed 14-bit result into five display codes (digits, blank,
// minus) using a 14-step serial double-dabble conversion.
module display_formatter
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4
);

  state_t            state;
  logic              sign;
  logic [VAL_W-1:0]  mag;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [3:0]        count;
  logic [NDIG*4-1:0] fmt;

  // One add-3 corrector per BCD nibble
  for (genvar g = 0; g < 4; g++) begin : g_adj
    bcd_adj3 u_adj (
      .nibble_in (bcd[g*4 +: 4]),
      .nibble_out(bcd_adj[g*4 +: 4])
    );
  end

  assign fmt = format_digits(bcd, sign);

  // Conversion FSM: capture on start, shift 14 times, then publish digits
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sign   <= 1'b0;
      mag    <= '0;
      bcd    <= '0;
      count  <= '0;
      digit0 <= 4'd0;
      digit1 <= DIG_BLANK;
      digit2 <= DIG_BLANK;
      digit3 <= DIG_BLANK;
      digit4 <= DIG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign  <= value[VAL_W-1];
            mag   <= value[VAL_W-1] ? (~value + 14'd1) : value;
            bcd   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          count      <= count + 4'd1;
          if (count == 4'd13) state <= FORMAT;
        end
        FORMAT: begin
          {digit4, digit3, digit2, digit1, digit0} <= fmt;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
